// File: rtl/dot_product_seq_pkg.sv
// Shared definitions for the dot-product sequencer and other accumulate blocks.
package dot_product_seq_pkg;

  localparam int OPW    = 4;
  localparam int PW     = 8;
  localparam int SEXT_W = 64;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ACC   = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    ISSUE = S_ISSUE,
    WAIT  = S_WAIT,
    ACC   = S_ACC,
    OUT   = S_OUT
  } state_t;

  // Sign-extend a product to a wide word; callers size-cast to their accumulator width.
  function automatic logic [SEXT_W-1:0] sign_extend_p(input logic [PW-1:0] v);
    return {{(SEXT_W-PW){v[PW-1]}}, v};
  endfunction

endpackage

// File: rtl/dot_product_seq_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module dot_product_seq_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Clear wins over increment; increment stops at the all-ones value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/dot_product_seq.sv
// Streams signed 4-bit operand pairs through a shared sequential multiplier
// and accumulates the products into a dot product released on valid/ready.
//
// state | meaning
// IDLE  | ready for an operand pair; latches it into mul_a/mul_b on in_valid
// ISSUE | one-cycle start pulse to the multiplier
// WAIT  | waiting for a rising edge on mul_done
// ACC   | add the sign-extended product into the accumulator
// OUT   | result offered downstream; input back-pressured until accepted
module dot_product_seq
  import dot_product_seq_pkg::*;
#(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_a,
  input  logic [OPW-1:0]   in_b,
  input  logic             in_last,
  output logic             mul_strt,
  output logic [OPW-1:0]   mul_a,
  output logic [OPW-1:0]   mul_b,
  input  logic [PW-1:0]    mul_p,
  input  logic             mul_done,
  output logic [ACC_W-1:0] sum,
  output logic [CNT_W-1:0] sum_count,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic             overflow
);

  state_t             state, state_nxt;
  logic               last_q;
  logic               done_prev;
  logic               done_rise;
  logic [PW-1:0]      p_q;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   acc_sum;
  logic               ovf_now;
  logic               accept;
  logic               release_sum;

  // A done level left high from an earlier operation must not count as completion.
  assign done_rise   = mul_done && !done_prev;
  assign accept      = (state == IDLE) && in_valid;
  assign release_sum = (state == OUT) && sum_ready;

  assign prod_ext = ACC_W'(sign_extend_p(p_q));
  assign acc_sum  = acc + prod_ext;
  assign ovf_now  = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);

  assign sum = acc;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mul_strt  = 1'b0;
    sum_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        mul_strt  = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (done_rise) state_nxt = ACC;
      end
      ACC: begin
        state_nxt = last_q ? OUT : IDLE;
      end
      OUT: begin
        sum_valid = 1'b1;
        if (sum_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are captured only on acceptance so they stay stable through WAIT.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mul_a  <= '0;
      mul_b  <= '0;
      last_q <= 1'b0;
    end else if (accept) begin
      mul_a  <= in_a;
      mul_b  <= in_b;
      last_q <= in_last;
    end
  end

  // Edge history of mul_done plus product capture on completion.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_prev <= 1'b1;
      p_q       <= '0;
    end else begin
      done_prev <= mul_done;
      if ((state == WAIT) && done_rise) p_q <= mul_p;
    end
  end

  // Accumulate with wrap-around; overflow stays set until the result is taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc      <= '0;
      overflow <= 1'b0;
    end else if (state == ACC) begin
      acc      <= acc_sum;
      overflow <= overflow | ovf_now;
    end else if (release_sum) begin
      acc      <= '0;
      overflow <= 1'b0;
    end
  end

  dot_product_seq_sat_counter #(
    .CNT_W (CNT_W)
  ) u_pair_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (release_sum),
    .inc   (state == ACC),
    .count (sum_count)
  );

endmodule

// File: tb/tb_dot_product_seq.sv
// Scoreboard bench: two sequencers (16-bit and 8-bit accumulators) share one
// behavioural multiplier; expected results are queued as pairs are issued.
module tb_dot_product_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_a = '0;
  logic [3:0]  in_b = '0;
  logic        in_last = 1'b0;
  logic [7:0]  mul_p = '0;
  logic        mul_done = 1'b0;
  logic        sum_ready = 1'b1;

  logic        in_ready, mul_strt, sum_valid, overflow;
  logic [3:0]  mul_a, mul_b;
  logic [15:0] sum;
  logic [7:0]  sum_count;

  logic        in_ready8, mul_strt8, sum_valid8, overflow8;
  logic [3:0]  mul_a8, mul_b8;
  logic [7:0]  sum8;
  logic [7:0]  sum_count8;

  typedef struct {
    logic [15:0] s16;
    logic [7:0]  s8;
    logic [7:0]  cnt;
    logic        o16;
    logic        o8;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   strt_cnt = 0;
  int   mul_lat = 3;
  int   done_hold = 0;
  bit   stab_en = 1'b1;
  int   waits;

  always #5 clock = ~clock;

  dot_product_seq #(.ACC_W(16), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_strt(mul_strt),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .mul_done(mul_done),
    .sum(sum), .sum_count(sum_count), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .overflow(overflow)
  );

  dot_product_seq #(.ACC_W(8), .CNT_W(8)) dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready8),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_strt(mul_strt8),
    .mul_a(mul_a8), .mul_b(mul_b8), .mul_p(mul_p), .mul_done(mul_done),
    .sum(sum8), .sum_count(sum_count8), .sum_valid(sum_valid8),
    .sum_ready(sum_ready), .overflow(overflow8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] s16, input logic [7:0] s8, input logic [7:0] cnt,
                      input logic o16, input logic o8);
    exp_t e;
    e.s16 = s16; e.s8 = s8; e.cnt = cnt; e.o16 = o16; e.o8 = o8;
    sb_q.push_back(e);
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic last, output int w);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last; w = 0;
    while (!in_ready && w < 500) begin
      @(negedge clock);
      w++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || sum_valid) && n < 500) begin
      @(negedge clock);
      n++;
    end
    if (n >= 500) check("drain_timeout", 32'd0, 32'd1);
  endtask

  // Behavioural shared multiplier: reacts to start, optionally keeps an old done level high.
  initial begin
    logic signed [3:0] pa, pb;
    logic signed [7:0] pp;
    forever begin
      @(negedge clock);
      if (mul_strt && reset) begin
        strt_cnt++;
        pa = mul_a; pb = mul_b;
        if (done_hold > 0) begin
          mul_p = 8'h55;
          repeat (done_hold) begin
            @(negedge clock);
            if (stab_en) begin
              check("mul_a_hold", {28'd0, mul_a}, {28'd0, pa});
              check("mul_b_hold", {28'd0, mul_b}, {28'd0, pb});
            end
          end
        end
        mul_done = 1'b0;
        repeat (mul_lat) begin
          @(negedge clock);
          if (stab_en) begin
            check("mul_a_wait", {28'd0, mul_a}, {28'd0, pa});
            check("mul_b_wait", {28'd0, mul_b}, {28'd0, pb});
          end
        end
        pp = pa * pb;
        mul_p = pp;
        mul_done = 1'b1;
      end
    end
  end

  // Monitor: compare each accepted result against the head of the scoreboard.
  initial begin
    logic strt_prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clock);
      #1;
      if (mul_strt && strt_prev) check("strt_width", 32'd2, 32'd1);
      strt_prev = mul_strt;
      if (sum_valid && sum_ready) begin
        check("valid_match", {31'd0, sum_valid8}, 32'd1);
        if (sb_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("sum16", {16'd0, sum}, {16'd0, e.s16});
          check("sum8", {24'd0, sum8}, {24'd0, e.s8});
          check("sum_count", {24'd0, sum_count}, {24'd0, e.cnt});
          check("sum_count8", {24'd0, sum_count8}, {24'd0, e.cnt});
          check("overflow16", {31'd0, overflow}, {31'd0, e.o16});
          check("overflow8", {31'd0, overflow8}, {31'd0, e.o8});
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_mul_strt"}, {31'd0, mul_strt}, 32'd0);
    check({tag, "_mul_ab"}, {24'd0, mul_a, mul_b}, 32'd0);
    check({tag, "_sum"}, {16'd0, sum}, 32'd0);
    check({tag, "_sum8"}, {24'd0, sum8}, 32'd0);
    check({tag, "_sum_count"}, {24'd0, sum_count}, 32'd0);
    check({tag, "_sum_valid"}, {30'd0, sum_valid, sum_valid8}, 32'd0);
    check({tag, "_overflow"}, {30'd0, overflow, overflow8}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int n;
    repeat (3) @(negedge clock);
    check_reset_values("rst");
    reset = 1'b1;
    @(negedge clock);

    // Single pair: -5 * -3 = 15
    push(16'd15, 8'd15, 8'd1, 1'b0, 1'b0);
    send(4'hB, 4'hD, 1'b1, waits);
    drain();

    // Three pairs: 6 - 20 + 49 = 35, three single-cycle starts
    s0 = strt_cnt;
    push(16'd35, 8'd35, 8'd3, 1'b0, 1'b0);
    send(4'd3, 4'd2, 1'b0, waits);
    send(4'hC, 4'd5, 1'b0, waits);
    send(4'd7, 4'd7, 1'b1, waits);
    drain();
    check("strt_count", strt_cnt - s0, 32'd3);

    // 3 x 49 = 147: fits 16 bits, wraps to 0x93 with overflow at 8 bits
    push(16'd147, 8'h93, 8'd3, 1'b0, 1'b1);
    send(4'd7, 4'd7, 1'b0, waits);
    send(4'd7, 4'd7, 1'b0, waits);
    send(4'd7, 4'd7, 1'b1, waits);
    drain();
    check("ovf8_cleared", {31'd0, overflow8}, 32'd0);
    check("sum8_cleared", {24'd0, sum8}, 32'd0);

    // Back-pressure: result held, offered pair refused until handshake
    sum_ready = 1'b0;
    push(16'd1, 8'd1, 8'd1, 1'b0, 1'b0);
    send(4'd1, 4'd1, 1'b1, waits);
    n = 0;
    while (!sum_valid && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("bp_valid_seen", {31'd0, sum_valid}, 32'd1);
    in_valid = 1'b1; in_a = 4'd2; in_b = 4'd2; in_last = 1'b1;
    repeat (10) begin
      @(negedge clock);
      check("bp_sum_stable", {16'd0, sum}, 32'd1);
      check("bp_in_ready", {30'd0, in_ready, in_ready8}, 32'd0);
      check("bp_valid_held", {31'd0, sum_valid}, 32'd1);
    end
    push(16'd4, 8'd4, 8'd1, 1'b0, 1'b0);
    sum_ready = 1'b1;
    send(4'd2, 4'd2, 1'b1, waits);
    check("bp_accept_delay", waits, 32'd1);
    drain();

    // Done level still high from the previous product: 3 * -2 = -6
    done_hold = 4;
    push(16'hFFFA, 8'hFA, 8'd1, 1'b0, 1'b0);
    send(4'd3, 4'hE, 1'b1, waits);
    drain();
    done_hold = 0;

    // Reset during WAIT after two accumulated pairs discards the partial sum
    send(4'd2, 4'd2, 1'b0, waits);
    send(4'd3, 4'd3, 1'b0, waits);
    stab_en = 1'b0;
    mul_lat = 20;
    send(4'd1, 4'd1, 1'b0, waits);
    repeat (3) @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_reset_values("midrst");
    @(negedge clock);
    reset = 1'b1;
    repeat (30) @(negedge clock);
    mul_lat = 3;
    stab_en = 1'b1;
    push(16'd6, 8'd6, 8'd1, 1'b0, 1'b0);
    send(4'd2, 4'd3, 1'b1, waits);
    drain();

    check("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
